// File: rtl/subleq_exec_core.sv
// ---------------------------------------------------------------------------
// subleq_exec_core
//
// Instruction sequencer for an 8-bit SUBLEQ machine. Every instruction takes
// six cycles: fetch A, B and C from pc..pc+2, read mem[A] and mem[B], then
// issue one registered write of mem[B]-mem[A] back to address B. The core
// branches to C when that result is zero or negative (signed), else it
// advances to pc+3. The write port feeds an I/O-port/RAM decoder, so a write
// to address 0 is passed through untouched.
//
// Optional feature (compile-time macro SUBLEQ_HALT_EN):
//   A taken branch to HALT_ADDR performs its write, then parks the core in
//   S_HALT with halted=1 until RST. Without the macro, HALT_ADDR is an
//   ordinary target and halted is tied low.
//
// Ports
//   CLK        in   1       system clock, rising edge
//   RST        in   1       asynchronous reset, active-high
//   RUN        in   1       start/continue, sampled only in S_FA
//   addrRead   out  ADDR_W  combinational RAM read address
//   dataRead   in   DATA_W  RAM read data, valid in the same cycle
//   addrWrite  out  ADDR_W  registered write address
//   dataWrite  out  DATA_W  registered write data
//   WE         out  1       registered write enable, one-cycle pulse
//   pc         out  ADDR_W  current program counter
//   instr_done out  1       one-cycle pulse coincident with WE
//   halted     out  1       core stopped (SUBLEQ_HALT_EN only, else 0)
// ---------------------------------------------------------------------------
module subleq_exec_core #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] HALT_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RUN,
  output logic [ADDR_W-1:0] addrRead,
  input  logic [DATA_W-1:0] dataRead,
  output logic [ADDR_W-1:0] addrWrite,
  output logic [DATA_W-1:0] dataWrite,
  output logic              WE,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_done,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FA,   // fetch operand address A from pc
    S_FB,   // fetch operand address B from pc+1
    S_FC,   // fetch branch target C from pc+2
    S_RA,   // read mem[A]
    S_RB,   // read mem[B], compute and register the write
    S_WR    // write is on the bus; choose the next pc
`ifdef SUBLEQ_HALT_EN
    , S_HALT // parked after a taken branch to HALT_ADDR
`endif
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] a_q;
  logic [ADDR_W-1:0] b_q;
  logic [ADDR_W-1:0] c_q;
  logic [DATA_W-1:0] op_a;

  // mem[B] - mem[A]; two's-complement wrap, overflow deliberately ignored.
  logic [DATA_W-1:0] result;
  assign result = dataRead - op_a;

  // The registered result is still on dataWrite during S_WR, so the branch
  // decision reads it from there instead of keeping a second copy.
  logic branch_taken;
  assign branch_taken = dataWrite[DATA_W-1] | (dataWrite == '0);

  // NOTE: every signal written in an always_comb gets a default first so no
  // path through the case statement leaves it unassigned (no latch).
  always_comb begin
    addrRead = '0;
    unique case (state)
      S_FA:    addrRead = pc;
      S_FB:    addrRead = pc + ADDR_W'(1);
      S_FC:    addrRead = pc + ADDR_W'(2);
      S_RA:    addrRead = a_q;
      S_RB:    addrRead = b_q;
      default: addrRead = '0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // Async reset drops WE immediately, so a half-finished instruction can
      // never leak a write onto the bus.
      state      <= S_FA;
      pc         <= RESET_PC;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      op_a       <= '0;
      addrWrite  <= '0;
      dataWrite  <= '0;
      WE         <= 1'b0;
      instr_done <= 1'b0;
`ifdef SUBLEQ_HALT_EN
      halted     <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_FA: begin
          // RUN only gates the start of an instruction; once under way the
          // sequence always completes.
          if (RUN) begin
            a_q   <= dataRead;
            state <= S_FB;
          end
        end
        S_FB: begin
          b_q   <= dataRead;
          state <= S_FC;
        end
        S_FC: begin
          c_q   <= dataRead;
          state <= S_RA;
        end
        S_RA: begin
          op_a  <= dataRead;
          state <= S_RB;
        end
        S_RB: begin
          addrWrite  <= b_q;
          dataWrite  <= result;
          WE         <= 1'b1;
          instr_done <= 1'b1;
          state      <= S_WR;
        end
        S_WR: begin
          // The RAM commits on this edge, so the next S_FA already sees the
          // new value (self-modifying code works without extra stalls).
          WE         <= 1'b0;
          instr_done <= 1'b0;
`ifdef SUBLEQ_HALT_EN
          if (branch_taken && (c_q == HALT_ADDR)) begin
            pc     <= HALT_ADDR;
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            pc    <= branch_taken ? c_q : pc + ADDR_W'(3);
            state <= S_FA;
          end
`else
          pc    <= branch_taken ? c_q : pc + ADDR_W'(3);
          state <= S_FA;
`endif
        end
`ifdef SUBLEQ_HALT_EN
        S_HALT: state <= S_HALT;
`endif
        default: state <= S_FA;
      endcase
    end
  end

`ifndef SUBLEQ_HALT_EN
  assign halted = 1'b0;
  // HALT_ADDR has no function in this build; reference it so it is not
  // reported as an unused parameter.
  logic unused_halt_addr;
  assign unused_halt_addr = ^HALT_ADDR;
`endif

endmodule
